// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code values, FSM state
// encoding and the decode that decides whether an operation runs digit-serially.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BIN  = 2'd1,
        S_DEC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Decimal mode only changes ADD and SUB; every other op stays single-cycle.
    function automatic logic is_dec_op(input logic [3:0] op, input logic dec_en);
        return dec_en && ((op == OP_ADD) || (op == OP_SUB));
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of decimal add/subtract with the +6 / +10 adjust; purely
// combinational, stepped across the operand one digit per clock by the top.
module bcd_digit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    input  logic       sub_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] add_raw;
    logic [5:0] sub_raw;

    always_comb begin
        add_raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
        // Six bits hold a - b - borrow over -16..15; bit 5 is the sign.
        sub_raw = {2'b0, a_i} - {2'b0, b_i} - {5'b0, ~cin_i};
        sum_o   = add_raw[3:0];
        cout_o  = 1'b0;
        if (sub_i) begin
            if (sub_raw[5]) begin
                sum_o  = sub_raw[3:0] + 4'd10;
                cout_o = 1'b0;
            end else begin
                sum_o  = sub_raw[3:0];
                cout_o = 1'b1;
            end
        end else if (add_raw > 5'd9) begin
            sum_o  = add_raw[3:0] + 4'd6;
            cout_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: binary ops finish one cycle after start, decimal ADD/SUB
// walk the operands one BCD digit per cycle through a single bcd_digit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             dec_en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovflw,
    output logic             zero,
    output logic             neg
);

    localparam int NDIG = WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB  = WIDTH - 1;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] da_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-5:0] acc_q;
    logic             dcarry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q;
    logic             v_q;
    logic             z_q;
    logic             n_q;

    logic             accept;
    logic             accept_dec;
    logic             last_digit;
    logic [3:0]       dig_sum;
    logic             dig_cout;
    logic [WIDTH-1:0] dec_word;
    logic [WIDTH-1:0] arith_b;
    logic [WIDTH:0]   arith_sum;
    logic             arith_v;
    logic [WIDTH-1:0] bin_r;
    logic             bin_c;
    logic             bin_v;
    logic [WIDTH-1:0] fin_r;
    logic             fin_c;
    logic             fin_v;

    // Only the digit-serial state blocks a new request; BIN and DONE accept.
    assign accept     = start && (state_q != S_DEC);
    assign accept_dec = is_dec_op(op, dec_en);
    assign last_digit = (cnt_q == CW'(NDIG - 1));

    bcd_digit u_digit (
        .a_i    (da_q[3:0]),
        .b_i    (db_q[3:0]),
        .cin_i  (dcarry_q),
        .sub_i  (op_q == OP_SUB),
        .sum_o  (dig_sum),
        .cout_o (dig_cout)
    );

    // New digit enters at the top; after NDIG steps the word is in place.
    assign dec_word = {dig_sum, acc_q};

    always_comb begin
        arith_b   = (op_q == OP_SUB) ? ~b_q : b_q;
        arith_sum = {1'b0, a_q} + {1'b0, arith_b} + {{WIDTH{1'b0}}, cin_q};
        arith_v   = (a_q[MSB] == arith_b[MSB]) && (arith_sum[MSB] != a_q[MSB]);

        bin_r = '0;
        bin_c = 1'b0;
        bin_v = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                bin_r = arith_sum[MSB:0];
                bin_c = arith_sum[WIDTH];
                bin_v = arith_v;
            end
            OP_AND: bin_r = a_q & b_q;
            OP_OR:  bin_r = a_q | b_q;
            OP_XOR: bin_r = a_q ^ b_q;
            OP_ASL: begin
                bin_r = {a_q[MSB-1:0], 1'b0};
                bin_c = a_q[MSB];
            end
            OP_LSR: begin
                bin_r = {1'b0, a_q[MSB:1]};
                bin_c = a_q[0];
            end
            OP_ROL: begin
                bin_r = {a_q[MSB-1:0], cin_q};
                bin_c = a_q[MSB];
            end
            OP_ROR: begin
                bin_r = {cin_q, a_q[MSB:1]};
                bin_c = a_q[0];
            end
            default: ;
        endcase

        if (state_q == S_DEC) begin
            fin_r = dec_word;
            fin_c = dig_cout;
            fin_v = arith_v;
        end else begin
            fin_r = bin_r;
            fin_c = bin_c;
            fin_v = bin_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            da_q     <= '0;
            db_q     <= '0;
            acc_q    <= '0;
            dcarry_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_BIN: begin
                    result_q <= fin_r;
                    c_q      <= fin_c;
                    v_q      <= fin_v;
                    z_q      <= (fin_r == '0);
                    n_q      <= fin_r[MSB];
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DEC: begin
                    acc_q    <= dec_word[WIDTH-1:4];
                    da_q     <= {4'b0, da_q[WIDTH-1:4]};
                    db_q     <= {4'b0, db_q[WIDTH-1:4]};
                    dcarry_q <= dig_cout;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_digit) begin
                        result_q <= fin_r;
                        c_q      <= fin_c;
                        v_q      <= fin_v;
                        z_q      <= (fin_r == '0);
                        n_q      <= fin_r[MSB];
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // A launch overrides the state step above (back-to-back / DONE restart).
            if (accept) begin
                op_q     <= op;
                a_q      <= a_in;
                b_q      <= b_in;
                cin_q    <= carry_in;
                da_q     <= a_in;
                db_q     <= b_in;
                dcarry_q <= carry_in;
                acc_q    <= '0;
                cnt_q    <= '0;
                busy_q   <= accept_dec;
                state_q  <= accept_dec ? S_DEC : S_BIN;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = c_q;
    assign ovflw     = v_q;
    assign zero      = z_q;
    assign neg       = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Drives an 8-bit and a 16-bit alu_seq with identical stimulus and checks both
// against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic        dec_en;
    logic        carry_in;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        busy8, done8, c8, v8, z8, n8;
    logic [7:0]  res8;
    logic        busy16, done16, c16, v16, z16, n16;
    logic [15:0] res16;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        longint r;
        bit     c;
        bit     v;
        bit     z;
        bit     n;
    } exp_t;

    typedef struct {
        int     op;
        bit     dec;
        longint a;
        longint b;
        bit     cin;
        bit     lit8;
        longint r8;
        bit     c8;
        bit     lit16;
        longint r16;
        bit     c16;
    } vec_t;

    bit     busy_s[2];
    bit     done_s[2];
    longint res_s[2];
    bit     c_s[2];
    bit     v_s[2];
    bit     z_s[2];
    bit     n_s[2];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dec_en(dec_en),
        .a_in(a_in[7:0]), .b_in(b_in[7:0]), .carry_in(carry_in),
        .busy(busy8), .done(done8), .result(res8),
        .carry_out(c8), .ovflw(v8), .zero(z8), .neg(n8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dec_en(dec_en),
        .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
        .busy(busy16), .done(done16), .result(res16),
        .carry_out(c16), .ovflw(v16), .zero(z16), .neg(n16)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    // Reference: plain integer arithmetic straight from the op definitions.
    function automatic exp_t model(input int w, input int op_v, input bit dec_v,
                                   input longint a_v, input longint b_v, input bit cin_v);
        exp_t   e;
        longint modv, half, a, b, bb, s, sa, sb, t, dig, cy, da, db;
        modv = longint'(1) << w;
        half = modv / 2;
        a = a_v % modv;
        b = b_v % modv;
        e.r = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op_v)
            0, 1: begin
                bb = (op_v == 1) ? (modv - 1 - b) : b;
                s  = a + bb + longint'(cin_v);
                e.r = s % modv;
                e.c = (s >= modv);
                sa = (a >= half) ? a - modv : a;
                sb = (bb >= half) ? bb - modv : bb;
                t  = sa + sb + longint'(cin_v);
                e.v = (t >= half) || (t < -half);
                if (dec_v) begin
                    e.r = 0;
                    cy  = longint'(cin_v);
                    for (int i = 0; i < w / 4; i++) begin
                        da = (a >> (4 * i)) % 16;
                        db = (b >> (4 * i)) % 16;
                        if (op_v == 0) begin
                            dig = da + db + cy;
                            if (dig > 9) begin dig = dig + 6; cy = 1; end
                            else cy = 0;
                        end else begin
                            dig = da - db - (1 - cy);
                            if (dig < 0) begin dig = dig + 10; cy = 0; end
                            else cy = 1;
                        end
                        e.r = e.r + ((((dig % 16) + 16) % 16) << (4 * i));
                    end
                    e.c = (cy != 0);
                end
            end
            2: e.r = a & b;
            3: e.r = a | b;
            4: e.r = a ^ b;
            5: begin e.r = (a * 2) % modv;                     e.c = (a >= half);   end
            6: begin e.r = a / 2;                              e.c = (a % 2 != 0);  end
            7: begin e.r = (a * 2 + longint'(cin_v)) % modv;   e.c = (a >= half);   end
            8: begin e.r = a / 2 + (cin_v ? half : 0);         e.c = (a % 2 != 0);  end
            default: ;
        endcase
        e.z = (e.r == 0);
        e.n = (e.r >= half);
        return e;
    endfunction

    task automatic read_outs();
        busy_s[0] = busy8;  done_s[0] = done8;  res_s[0] = longint'(res8);
        c_s[0] = c8;  v_s[0] = v8;  z_s[0] = z8;  n_s[0] = n8;
        busy_s[1] = busy16; done_s[1] = done16; res_s[1] = longint'(res16);
        c_s[1] = c16; v_s[1] = v16; z_s[1] = z16; n_s[1] = n16;
    endtask

    task automatic drive(input int op_v, input bit dec_v, input longint a_v,
                         input longint b_v, input bit cin_v, input bit st);
        op       = 4'(op_v);
        dec_en   = dec_v;
        a_in     = 16'(a_v);
        b_in     = 16'(b_v);
        carry_in = cin_v;
        start    = st;
    endtask

    task automatic check_flags(input string tag, input int d, input exp_t e,
                               input longint r, input bit c, input bit v, input bit z, input bit n);
        string p;
        p = $sformatf("%s w%0d", tag, wid(d));
        check({p, " R"}, r, e.r);
        check({p, " C"}, longint'(c), longint'(e.c));
        check({p, " V"}, longint'(v), longint'(e.v));
        check({p, " Z"}, longint'(z), longint'(e.z));
        check({p, " N"}, longint'(n), longint'(e.n));
    endtask

    // Called at a falling edge; the start edge is the next rising edge.
    task automatic do_op(input string tag, input int op_v, input bit dec_v, input longint a_v,
                         input longint b_v, input bit cin_v, input bit inject);
        exp_t   e[2];
        int     lat[2], nb[2], nd[2];
        longint cr[2];
        bit     cc[2], cv[2], cz[2], cn[2];
        bit     is_dec;
        is_dec = dec_v && (op_v == 0 || op_v == 1);
        for (int d = 0; d < 2; d++) begin
            e[d] = model(wid(d), op_v, dec_v, a_v, b_v, cin_v);
            lat[d] = -1; nb[d] = 0; nd[d] = 0;
            cr[d] = 0; cc[d] = 0; cv[d] = 0; cz[d] = 0; cn[d] = 0;
        end
        drive(op_v, dec_v, a_v, b_v, cin_v, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            read_outs();
            for (int d = 0; d < 2; d++) begin
                if (busy_s[d]) nb[d]++;
                if (done_s[d]) begin
                    nd[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = k;
                        cr[d] = res_s[d]; cc[d] = c_s[d]; cv[d] = v_s[d];
                        cz[d] = z_s[d];   cn[d] = n_s[d];
                    end
                end
            end
            if (k == 0 && inject) drive(0, 1'b0, 'h11, 'h22, 1'b0, 1'b1);
            else drive(int'($urandom_range(0, 15)), 1'($urandom), longint'($urandom),
                       longint'($urandom), 1'($urandom), 1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s w%0d latency", tag, wid(d)), longint'(lat[d]),
                  is_dec ? longint'(wid(d) / 4) : 1);
            check($sformatf("%s w%0d busy_cycles", tag, wid(d)), longint'(nb[d]),
                  is_dec ? longint'(wid(d) / 4) : 0);
            check($sformatf("%s w%0d done_pulses", tag, wid(d)), longint'(nd[d]), 1);
            check_flags(tag, d, e[d], cr[d], cc[d], cv[d], cz[d], cn[d]);
            check($sformatf("%s w%0d hold R", tag, wid(d)), res_s[d], e[d].r);
        end
        $display("op %s: op=%0d dec=%0d a=%h b=%h cin=%0d -> r8=%h r16=%h",
                 tag, op_v, dec_v, a_v, b_v, cin_v, cr[0], cr[1]);
    endtask

    // Two binary ops; the second starts 'gap' cycles after the first start edge + 1.
    task automatic b2b(input string tag, input int gap);
        exp_t   e1[2], e2[2];
        int     op1, op2, nd[2];
        longint a1, b1, a2, b2;
        bit     c1, c2;
        op1 = int'($urandom_range(0, 8)); op2 = int'($urandom_range(0, 8));
        a1 = longint'($urandom_range(0, 65535)); b1 = longint'($urandom_range(0, 65535));
        a2 = longint'($urandom_range(0, 65535)); b2 = longint'($urandom_range(0, 65535));
        c1 = 1'($urandom); c2 = 1'($urandom);
        for (int d = 0; d < 2; d++) begin
            e1[d] = model(wid(d), op1, 1'b0, a1, b1, c1);
            e2[d] = model(wid(d), op2, 1'b0, a2, b2, c2);
            nd[d] = 0;
        end
        drive(op1, 1'b0, a1, b1, c1, 1'b1);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            read_outs();
            for (int d = 0; d < 2; d++) begin
                if (done_s[d]) nd[d]++;
                if (n == 2) begin
                    check($sformatf("%s w%0d done1", tag, wid(d)), longint'(done_s[d]), 1);
                    check_flags({tag, " op1"}, d, e1[d], res_s[d], c_s[d], v_s[d], z_s[d], n_s[d]);
                end
                if (n == 3 + gap) begin
                    check($sformatf("%s w%0d done2", tag, wid(d)), longint'(done_s[d]), 1);
                    check_flags({tag, " op2"}, d, e2[d], res_s[d], c_s[d], v_s[d], z_s[d], n_s[d]);
                end
            end
            if (n == 1 + gap) drive(op2, 1'b0, a2, b2, c2, 1'b1);
            else drive(op2, 1'b0, a2, b2, c2, 1'b0);
        end
        for (int d = 0; d < 2; d++)
            check($sformatf("%s w%0d done_count", tag, wid(d)), longint'(nd[d]), 2);
        $display("b2b %s: gap=%0d op1=%0d op2=%0d", tag, gap, op1, op2);
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z.r = 0; z.c = 0; z.v = 0; z.z = 0; z.n = 0;
        read_outs();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s w%0d busy", tag, wid(d)), longint'(busy_s[d]), 0);
            check($sformatf("%s w%0d done", tag, wid(d)), longint'(done_s[d]), 0);
            check_flags(tag, d, z, res_s[d], c_s[d], v_s[d], z_s[d], n_s[d]);
        end
    endtask

    task automatic reset_abort();
        int nd;
        drive(0, 1'b1, 'h5858, 'h4646, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        read_outs();
        check("abort busy_before w8", longint'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done8 || done16) nd++;
        end
        check("abort no_done", longint'(nd), 0);
        rst_n = 1'b1;
        $display("reset abort during DEC done");
    endtask

    vec_t dir[$];

    initial begin
        rst_n = 1'b1;
        drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        dir.push_back('{0, 1'b0, 'h50,   'h50,   1'b0, 1'b1, 'hA0, 1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{0, 1'b1, 'h58,   'h46,   1'b1, 1'b1, 'h05, 1'b1, 1'b0, 0,      1'b0});
        dir.push_back('{1, 1'b1, 'h12,   'h21,   1'b1, 1'b1, 'h91, 1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{1, 1'b0, 'h00,   'h01,   1'b1, 1'b1, 'hFF, 1'b0, 1'b1, 'hFFFF, 1'b0});
        dir.push_back('{8, 1'b0, 'h01,   'h00,   1'b1, 1'b1, 'h80, 1'b1, 1'b1, 'h8000, 1'b1});
        dir.push_back('{6, 1'b0, 'h01,   'h00,   1'b0, 1'b1, 'h00, 1'b1, 1'b1, 'h0000, 1'b1});
        dir.push_back('{0, 1'b0, 'h5050, 'h5050, 1'b0, 1'b0, 0,    1'b0, 1'b1, 'hA0A0, 1'b0});
        dir.push_back('{0, 1'b1, 'h5858, 'h4646, 1'b1, 1'b0, 0,    1'b0, 1'b1, 'h0505, 1'b1});
        dir.push_back('{0, 1'b1, 'h9999, 'h0001, 1'b0, 1'b1, 'h00, 1'b1, 1'b1, 'h0000, 1'b1});
        dir.push_back('{1, 1'b1, 'h0000, 'h0001, 1'b1, 1'b1, 'h99, 1'b0, 1'b1, 'h9999, 1'b0});
        dir.push_back('{12, 1'b0, 'h33,  'h44,   1'b1, 1'b1, 'h00, 1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{2, 1'b1, 'hF0,   'h3C,   1'b1, 1'b1, 'h30, 1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{3, 1'b0, 'hF0,   'h3C,   1'b0, 1'b0, 0,    1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{4, 1'b0, 'hF0,   'h3C,   1'b0, 1'b0, 0,    1'b0, 1'b0, 0,      1'b0});
        dir.push_back('{5, 1'b0, 'h81,   'h00,   1'b0, 1'b1, 'h02, 1'b1, 1'b0, 0,      1'b0});
        dir.push_back('{7, 1'b1, 'h81,   'h00,   1'b1, 1'b1, 'h03, 1'b1, 1'b0, 0,      1'b0});

        foreach (dir[i]) begin
            do_op($sformatf("dir%0d", i), dir[i].op, dir[i].dec, dir[i].a, dir[i].b, dir[i].cin, 1'b0);
            if (dir[i].lit8) begin
                check($sformatf("dir%0d lit w8 R", i), longint'(res8), dir[i].r8);
                check($sformatf("dir%0d lit w8 C", i), longint'(c8), longint'(dir[i].c8));
            end
            if (dir[i].lit16) begin
                check($sformatf("dir%0d lit w16 R", i), longint'(res16), dir[i].r16);
                check($sformatf("dir%0d lit w16 C", i), longint'(c16), longint'(dir[i].c16));
            end
        end

        do_op("ignore", 0, 1'b1, 'h5858, 'h4646, 1'b1, 1'b1);
        check("ignore lit w8 R", longint'(res8), 'h05);

        reset_abort();
        do_op("after_reset", 1, 1'b1, 'h4321, 'h1234, 1'b1, 1'b0);

        b2b("b2b_gap0", 0);
        b2b("b2b_gap1", 1);

        for (int i = 0; i < 40; i++)
            do_op($sformatf("rnd%0d", i), int'($urandom_range(0, 15)), 1'($urandom),
                  longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
                  1'($urandom), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning datapath width in bits, a multiple of 4 in the range 8..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request an operation; sampled only when busy=0.
REQ-005 The block SHALL have port op, input, 4 bits, with these encodings:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 ASL, 6 LSR, 7 ROL, 8 ROR
REQ-006 The block SHALL have port dec_en, input, 1 bit: decimal (BCD) mode; honoured for ADD/SUB only.
REQ-007 The block SHALL have ports a_in and b_in, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port carry_in, input, 1 bit: carry in for ADD, SUB, ROL and ROR.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result and flags valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-012 The block SHALL have ports carry_out, ovflw, zero and neg, output, 1 bit each: flags C, V, Z and N.

Function
REQ-013 When start=1 and busy=0, the block SHALL latch op, dec_en, a_in, b_in and carry_in; later input changes SHALL NOT affect that operation.
REQ-014 Binary ops SHALL assert done exactly 1 cycle after the start edge; busy SHALL stay 0 throughout.
REQ-015 Decimal ADD/SUB SHALL take one cycle per BCD digit, least-significant digit first:
- busy=1 for WIDTH/4 cycles
- done one cycle after the last digit
REQ-016 The state machine SHALL have states IDLE, BIN, DEC and DONE, with these transitions:
- IDLE->BIN on start with a binary op
- IDLE->DEC on start with decimal ADD/SUB
- BIN->DONE
- DEC->DEC until the digit counter reaches WIDTH/4-1, then ->DONE
- DONE->IDLE
REQ-017 ADD SHALL compute {C,R} = A+B+Cin, with the sum taken at WIDTH+1 bits.
REQ-018 SUB SHALL compute A+~B+Cin, so C=1 means no borrow.
REQ-019 For binary ADD/SUB, V SHALL be set when both operands of the addition (A and B, or A and ~B) share a sign and R differs from it.
REQ-020 For decimal ADD, each digit SHALL compute s=a+b+c; if s>9 it SHALL add 6, with digit carry=1.
REQ-021 For decimal SUB, each digit SHALL compute d=a-b-(1-c); if d<0 it SHALL add 10, with digit borrow=1 and C=~borrow.
REQ-022 In decimal mode, V SHALL equal the binary-mode V for the same latched operands.
REQ-023 Non-BCD digits (>9) SHALL produce the arithmetic above without error indication.
REQ-024 AND, OR and XOR SHALL give C=0 and V=0.
REQ-025 Shift and rotate SHALL give V=0, with these results and carries:
- ASL: R={A[W-2:0],0}, C=A[W-1]
- LSR: R={0,A[W-1:1]}, C=A[0]
- ROL: R={A[W-2:0],Cin}, C=A[W-1]
- ROR: R={Cin,A[W-1:1]}, C=A[0]
REQ-026 For all ops, Z SHALL be (R==0) and N SHALL be R[WIDTH-1].
REQ-027 Op codes 9..15 SHALL complete as binary ops with R=0, C=0, V=0, Z=1, N=0.
REQ-028 result and the flags SHALL change only in the cycle done is asserted, then hold until the next done.
REQ-029 start while busy=1 SHALL be ignored, with no queueing.
REQ-030 start in the DONE cycle SHALL be accepted.
REQ-031 A back-to-back binary start SHALL yield done on consecutive cycles.

Reset
REQ-032 While rst_n=0, the block SHALL force state to IDLE, the digit counter to 0, busy=0, done=0, result=0 and carry_out=ovflw=zero=neg=0.
REQ-033 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-034 The first start SHALL be accepted on the first clk edge after rst_n deasserts.

Structure
REQ-035 Op-code localparams and FSM state encodings SHALL reside in shared package alu_pkg.
REQ-036 One sub-module, bcd_digit, SHALL provide the combinational 4-bit decimal add/subtract with adjust, instanced once and reused per cycle.

Verification
REQ-037 The bench SHALL cover these scenarios (WIDTH=8):
- ADD bin, A=0x50, B=0x50, Cin=0 -> after 1 cycle: R=0xA0, C=0, V=1, N=1, Z=0.
- ADD dec, A=0x58, B=0x46, Cin=1 -> busy 2 cycles, then done: R=0x05, C=1.
- SUB dec, A=0x12, B=0x21, Cin=1 -> R=0x91, C=0; SUB bin, A=0x00, B=0x01, Cin=1 -> R=0xFF, C=0, N=1.
- ROR, A=0x01, Cin=1 -> R=0x80, C=1, N=1; LSR, A=0x01 -> R=0x00, C=1, Z=1.
- start(ADD 0x11+0x22) during a decimal op -> ignored; outputs reflect only the first op.
- rst_n low during DEC -> no done; outputs 0; next start completes normally.
- Repeat scenarios 1-2 with WIDTH=16, e.g. dec 0x9999+0x0001 -> R=0x0000, C=1, Z=1, 4 busy cycles.
